// File: rtl/fp8_pkg.sv
// Shared FP8 (E4M3, bias 7) constants and the result-arbiter state type.
// Exponent 15 encodes NaN; there is no infinity, overflow saturates to max-finite.
package fp8_pkg;

   localparam int FP8_W     = 8;
   localparam int FP8_EXP_W = 4;
   localparam int FP8_MAN_W = 3;
   localparam int FP8_BIAS  = 7;

   localparam logic [FP8_W-1:0] FP8_NAN     = 8'h7F;
   localparam logic [FP8_W-1:0] FP8_MAX_FIN = 8'h77;

   typedef enum logic {
      ARB_EMPTY = 1'b0,
      ARB_FULL  = 1'b1
   } arb_state_t;

   function automatic logic fp8_is_nan(input logic [FP8_W-1:0] x);
      return x[6:3] == {FP8_EXP_W{1'b1}};
   endfunction

   function automatic logic fp8_is_zero(input logic [FP8_W-1:0] x);
      return x[6:0] == 7'd0;
   endfunction

endpackage

// File: rtl/fp8_mul_top.sv
// Combinational E4M3 multiplier: round-to-nearest-even, subnormal in/out,
// NaN in gives canonical NaN, zero operand gives +0, overflow saturates.
module fp8_mul_top
   import fp8_pkg::*;
(
   input  logic [FP8_W-1:0] i_a,
   input  logic [FP8_W-1:0] i_b,
   output logic [FP8_W-1:0] o_y
);

   logic        w_sign;
   logic [3:0]  w_sig_a;
   logic [3:0]  w_sig_b;
   int          w_exp_a;
   int          w_exp_b;
   logic [7:0]  w_prod;
   int          w_lead;
   int          w_exp_r;
   int          w_exp_eff;
   int          w_mag;
   logic [3:0]  w_sh;
   logic [26:0] w_ext;
   logic [26:0] w_shifted;
   logic [3:0]  w_q;
   logic        w_rnd;
   logic        w_stk;
   logic        w_inc;
   logic [4:0]  w_q_rnd;

   always_comb begin
      w_sign  = i_a[7] ^ i_b[7];
      w_sig_a = {(i_a[6:3] != 4'd0), i_a[2:0]};
      w_sig_b = {(i_b[6:3] != 4'd0), i_b[2:0]};
      w_exp_a = (i_a[6:3] == 4'd0) ? 1 : int'(i_a[6:3]);
      w_exp_b = (i_b[6:3] == 4'd0) ? 1 : int'(i_b[6:3]);
      w_prod  = {4'b0000, w_sig_a} * {4'b0000, w_sig_b};

      w_lead = 0;
      for (int i = 0; i < 8; i++) begin
         if (w_prod[i]) w_lead = i;
      end

      // Product value is w_prod * 2^(ea+eb-20); biased exponent of its leading one.
      w_exp_r = w_lead + w_exp_a + w_exp_b - (2 * FP8_MAN_W + FP8_BIAS);

      // Shift leaves the kept significand in bits [19:16]; subnormals use the fixed 2^-9 quantum.
      if (w_exp_r > 0) begin
         w_exp_eff = w_exp_r;
         w_sh      = 4'(w_lead);
      end else begin
         w_exp_eff = 1;
         w_sh      = 4'(2 * FP8_MAN_W + FP8_BIAS + 1 - w_exp_a - w_exp_b);
      end

      w_ext     = {w_prod, 3'b000, 16'h0000};
      w_shifted = w_ext >> w_sh;
      w_q       = 4'(w_shifted >> 16);
      w_rnd     = w_shifted[15];
      w_stk     = |w_shifted[14:0];
      w_inc     = w_rnd & (w_stk | w_q[0]);
      w_q_rnd   = {1'b0, w_q} + {4'b0000, w_inc};

      // Rounding carry into the next binade falls out of the additive encoding.
      w_mag = (w_exp_eff - 1) * 8 + int'(w_q_rnd);

      if (fp8_is_nan(i_a) || fp8_is_nan(i_b)) begin
         o_y = FP8_NAN;
      end else if (fp8_is_zero(i_a) || fp8_is_zero(i_b)) begin
         o_y = 8'h00;
      end else if (w_mag > int'(FP8_MAX_FIN)) begin
         o_y = {w_sign, FP8_MAX_FIN[6:0]};
      end else begin
         o_y = {w_sign, 7'(w_mag)};
      end
   end

endmodule

// File: rtl/fp8_mul_arb.sv
// Round-robin arbiter sharing one FP8 multiplier among NREQ requesters, 1-deep result register.
// Optional build macro FP8_MUL_ARB_NAN_FLAG_EN adds the registered rsp_nan output.
//
//   state     | meaning
//   ----------+----------------------------------------------
//   ARB_EMPTY | result register empty, rsp_valid = 0
//   ARB_FULL  | result register holds a product, rsp_valid = 1
module fp8_mul_arb
   import fp8_pkg::*;
#(
   parameter  int NREQ = 4,
   localparam int IDW  = $clog2(NREQ)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [8*NREQ-1:0]    req_a,
   input  logic [8*NREQ-1:0]    req_b,
   output logic [NREQ-1:0]      req_ready,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [FP8_W-1:0]     rsp_y,
   output logic [IDW-1:0]       rsp_id
`ifdef FP8_MUL_ARB_NAN_FLAG_EN
   ,
   output logic                 rsp_nan
`endif
);

   arb_state_t       r_state;
   arb_state_t       w_state_nxt;
   logic [IDW-1:0]   r_ptr;
   logic [IDW-1:0]   w_ptr_nxt;
   logic [IDW-1:0]   w_gnt_idx;
   logic [IDW-1:0]   w_idx;
   int               w_sum;
   logic             w_gnt_any;
   logic             w_can_accept;
   logic             w_xfer;
   logic [FP8_W-1:0] w_a;
   logic [FP8_W-1:0] w_b;
   logic [FP8_W-1:0] w_y;
   logic [FP8_W-1:0] r_y;
   logic [IDW-1:0]   r_id;

   // Picker looks only at req_valid and ptr so req_ready never depends on operand data.
   always_comb begin
      w_gnt_any = 1'b0;
      w_gnt_idx = '0;
      w_sum     = 0;
      w_idx     = '0;
      for (int off = 0; off < NREQ; off++) begin
         w_sum = int'(r_ptr) + off;
         if (w_sum >= NREQ) w_sum = w_sum - NREQ;
         w_idx = IDW'(w_sum);
         if (!w_gnt_any && req_valid[w_idx]) begin
            w_gnt_any = 1'b1;
            w_gnt_idx = w_idx;
         end
      end
   end

   always_comb begin
      w_can_accept = (r_state == ARB_EMPTY) | rsp_ready;
      w_xfer       = ~rst & w_can_accept & w_gnt_any;
      req_ready    = '0;
      if (w_xfer) req_ready[w_gnt_idx] = 1'b1;
   end

   always_comb begin
      w_a = '0;
      w_b = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (w_gnt_idx == IDW'(i)) begin
            w_a = req_a[i*8 +: 8];
            w_b = req_b[i*8 +: 8];
         end
      end
   end

   always_comb begin
      if (int'(w_gnt_idx) == NREQ - 1) begin
         w_ptr_nxt = '0;
      end else begin
         w_ptr_nxt = w_gnt_idx + IDW'(1);
      end
   end

   fp8_mul_top u_mul (
      .i_a (w_a),
      .i_b (w_b),
      .o_y (w_y)
   );

   always_ff @(posedge clk) begin
      if (rst) r_state <= ARB_EMPTY;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ARB_EMPTY: if (w_xfer) w_state_nxt = ARB_FULL;
         ARB_FULL:  if (rsp_ready && !w_xfer) w_state_nxt = ARB_EMPTY;
         default:   w_state_nxt = ARB_EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr <= '0;
         r_y   <= '0;
         r_id  <= '0;
      end else if (w_xfer) begin
         r_ptr <= w_ptr_nxt;
         r_y   <= w_y;
         r_id  <= w_gnt_idx;
      end
   end

`ifdef FP8_MUL_ARB_NAN_FLAG_EN
   logic w_nan;
   logic r_nan;

   assign w_nan = fp8_is_nan(w_a) | fp8_is_nan(w_b);

   always_ff @(posedge clk) begin
      if (rst)         r_nan <= 1'b0;
      else if (w_xfer) r_nan <= w_nan;
   end

   assign rsp_nan = r_nan;
`endif

   assign rsp_valid = (r_state == ARB_FULL);
   assign rsp_y     = r_y;
   assign rsp_id    = r_id;

endmodule

// File: tb/tb_fp8_mul_arb.sv
// Scoreboard bench for fp8_mul_arb: a reference-value FP8 model and a round-robin grant model.
module tb_fp8_mul_arb;

   localparam int NREQ = 4;
   localparam int IDW  = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic [NREQ-1:0]   req_valid;
   logic [8*NREQ-1:0] req_a;
   logic [8*NREQ-1:0] req_b;
   logic [NREQ-1:0]   req_ready;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [7:0]        rsp_y;
   logic [IDW-1:0]    rsp_id;
`ifdef FP8_MUL_ARB_NAN_FLAG_EN
   logic              rsp_nan;
`endif

   always #5 clk = ~clk;

   fp8_mul_arb #(.NREQ(NREQ)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_y     (rsp_y),
      .rsp_id    (rsp_id)
`ifdef FP8_MUL_ARB_NAN_FLAG_EN
      ,
      .rsp_nan   (rsp_nan)
`endif
   );

   typedef struct {
      logic [IDW-1:0] id;
      logic [7:0]     y;
      logic           nan;
   } rsp_t;

   rsp_t sb_q[$];
   int   gnt_log[$];
   int   m_ptr;
   bit   m_full;
   int   n_chk = 0;
   int   n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic real pow2(input int n);
      real r = 1.0;
      if (n >= 0) for (int i = 0; i < n; i++) r = r * 2.0;
      else        for (int i = 0; i < -n; i++) r = r / 2.0;
      return r;
   endfunction

   function automatic real fp8_mag(input logic [7:0] c);
      int e = int'(c[6:3]);
      int m = int'(c[2:0]);
      if (e == 0) return (real'(m) / 8.0) * pow2(-6);
      return (1.0 + real'(m) / 8.0) * pow2(e - 7);
   endfunction

   // Nearest representable magnitude by exhaustive search, ties to even code.
   function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
      real t, d, best_d;
      int  best;
      if (a[6:3] == 4'hF || b[6:3] == 4'hF) return 8'h7F;
      if (a[6:0] == 7'd0 || b[6:0] == 7'd0) return 8'h00;
      t      = fp8_mag(a) * fp8_mag(b);
      best   = 0;
      best_d = t;
      for (int c = 1; c <= 8'h77; c++) begin
         d = fp8_mag(8'(c)) - t;
         if (d < 0.0) d = -d;
         if (d < best_d || (d == best_d && c[0] == 1'b0)) begin
            best   = c;
            best_d = d;
         end
      end
      return {a[7] ^ b[7], best[6:0]};
   endfunction

   task automatic set_req(input int i, input logic v, input logic [7:0] a, input logic [7:0] b);
      req_valid[i[1:0]]             = v;
      req_a[{i[1:0], 3'b000} +: 8] = a;
      req_b[{i[1:0], 3'b000} +: 8] = b;
   endtask

   task automatic sample();
      logic [3:0] exp_rdy;
      logic [7:0] a8, b8;
      int         gi, idx;
      rsp_t       e;
      if (rst) begin
         chk("rst_req_ready", 32'(req_ready), 32'(0));
         m_ptr  = 0;
         m_full = 1'b0;
         sb_q.delete();
         return;
      end
      chk("rsp_valid", 32'(rsp_valid), 32'(m_full));
      if (rsp_valid) begin
         if (sb_q.size() == 0) begin
            chk("rsp_unexpected", 32'(1), 32'(0));
         end else begin
            chk("rsp_id", 32'(rsp_id), 32'(sb_q[0].id));
            chk("rsp_y", 32'(rsp_y), 32'(sb_q[0].y));
`ifdef FP8_MUL_ARB_NAN_FLAG_EN
            chk("rsp_nan", 32'(rsp_nan), 32'(sb_q[0].nan));
`endif
            if (rsp_ready) void'(sb_q.pop_front());
         end
      end
      gi = -1;
      if (!m_full || rsp_ready) begin
         for (int off = 0; off < NREQ; off++) begin
            idx = (m_ptr + off) % NREQ;
            if (gi < 0 && req_valid[idx[1:0]]) gi = idx;
         end
      end
      exp_rdy = (gi >= 0) ? 4'(1 << gi) : 4'b0000;
      chk("req_ready", 32'(req_ready), 32'(exp_rdy));
      for (int k = 0; k < NREQ; k++) begin
         if (req_ready[k[1:0]]) gnt_log.push_back(k);
      end
      if (gi >= 0) begin
         a8    = 8'(req_a >> (8 * gi));
         b8    = 8'(req_b >> (8 * gi));
         e.id  = IDW'(gi);
         e.y   = ref_mul(a8, b8);
         e.nan = (a8[6:3] == 4'hF) || (b8[6:3] == 4'hF);
         sb_q.push_back(e);
         m_ptr = (gi + 1) % NREQ;
      end
      m_full = (gi >= 0) || (m_full && !rsp_ready);
   endtask

   task automatic settle();
      #3;
      sample();
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic step();
      settle();
      tick();
   endtask

   task automatic set_all_valid();
      set_req(0, 1'b1, 8'h38, 8'h40);
      set_req(1, 1'b1, 8'h40, 8'h40);
      set_req(2, 1'b1, 8'h3C, 8'h44);
      set_req(3, 1'b1, 8'hB8, 8'h31);
   endtask

   int         exp_order[6] = '{0, 1, 2, 3, 0, 1};
   logic [7:0] sp_a[4]      = '{8'h70, 8'hF0, 8'h78, 8'h00};
   logic [7:0] sp_b[4]      = '{8'h70, 8'h70, 8'h38, 8'h48};
   logic [7:0] sp_y[4]      = '{8'h77, 8'hF7, 8'h7F, 8'h00};
   logic       sp_n[4]      = '{1'b0, 1'b0, 1'b1, 1'b0};
   logic [3:0] last_ready;

   initial begin
      rst       = 1'b1;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      rsp_ready = 1'b1;
      m_ptr     = 0;
      m_full    = 1'b0;
      tick();
      step();
      step();
      rst = 1'b0;
      chk("reset_rsp_valid", 32'(rsp_valid), 32'(0));
      chk("reset_rsp_y", 32'(rsp_y), 32'(0));
      chk("reset_rsp_id", 32'(rsp_id), 32'(0));

      // single request
      set_req(0, 1'b1, 8'h38, 8'h38);
      settle();
      chk("single_gnt", 32'(req_ready), 32'(4'b0001));
      tick();
      set_req(0, 1'b0, 8'h00, 8'h00);
      settle();
      chk("single_valid", 32'(rsp_valid), 32'(1));
      chk("single_y", 32'(rsp_y), 32'(8'h38));
      chk("single_id", 32'(rsp_id), 32'(0));
      tick();
      step();

      // fairness from ptr=0
      rst = 1'b1;
      step();
      rst = 1'b0;
      set_all_valid();
      gnt_log.delete();
      for (int i = 0; i < 6; i++) begin
         settle();
         if (i > 0) chk("fair_rsp_each_cycle", 32'(rsp_valid), 32'(1));
         if (rsp_valid && rsp_id == 2'd1) chk("fair_rq1_y", 32'(rsp_y), 32'(8'h48));
         tick();
      end
      chk("fair_count", 32'(gnt_log.size()), 32'(6));
      for (int i = 0; i < gnt_log.size() && i < 6; i++) begin
         chk("fair_order", 32'(gnt_log[i]), 32'(exp_order[i]));
      end

      // backpressure holds the rq1 result
      rsp_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         settle();
         chk("bp_req_ready", 32'(req_ready), 32'(0));
         chk("bp_rsp_id", 32'(rsp_id), 32'(1));
         chk("bp_rsp_y", 32'(rsp_y), 32'(8'h48));
         tick();
      end
      rsp_ready = 1'b1;
      settle();
      chk("bp_release_gnt", 32'(req_ready), 32'(4'b0100));
      tick();
      req_valid = '0;
      step();
      step();

      // special values through requester 3
      for (int i = 0; i < 4; i++) begin
         set_req(3, 1'b1, sp_a[i], sp_b[i]);
         step();
         set_req(3, 1'b0, 8'h00, 8'h00);
         settle();
         chk("special_valid", 32'(rsp_valid), 32'(1));
         chk("special_y", 32'(rsp_y), 32'(sp_y[i]));
`ifdef FP8_MUL_ARB_NAN_FLAG_EN
         chk("special_nan", 32'(rsp_nan), 32'(sp_n[i]));
`endif
         tick();
      end
      step();

      // reset mid-stream while FULL with ptr=2
      rst = 1'b1;
      step();
      rst = 1'b0;
      set_all_valid();
      step();
      step();
      rst = 1'b1;
      settle();
      chk("midrst_req_ready", 32'(req_ready), 32'(0));
      tick();
      rst = 1'b0;
      settle();
      chk("midrst_rsp_valid", 32'(rsp_valid), 32'(0));
      chk("midrst_first_gnt", 32'(req_ready), 32'(4'b0001));
      tick();

      // random traffic; requesters hold until granted
      last_ready = 4'b1111;
      for (int c = 0; c < 400; c++) begin
         for (int k = 0; k < NREQ; k++) begin
            if (!req_valid[k[1:0]] || last_ready[k[1:0]]) begin
               set_req(k, ($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom));
            end
         end
         rsp_ready = ($urandom_range(0, 3) != 0);
         settle();
         last_ready = req_ready;
         tick();
      end
      req_valid = '0;
      rsp_ready = 1'b1;
      step();
      step();
      step();
      chk("sb_drained", 32'(sb_q.size()), 32'(0));

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
